axi_read_dma: RTL and testbench
===============================

AXI_READ_DMA -- requirements
Module: axi_read_dma

Interface
REQ-001 SHALL have parameter AxiIdWidth, default 4, meaning AXI ID width.
REQ-002 SHALL have parameter AxiAddrWidth, default 64, meaning AXI address width.
REQ-003 SHALL have parameter AxiDataWidth, default 64, meaning AXI data and stream width.
REQ-004 SHALL have parameter MaxBurstLen, default 16, meaning maximum beats per AR burst (power of two, 1..256).
REQ-005 SHALL have parameter FifoDepth, default 32, meaning read-data buffer depth in beats (power of two, at least MaxBurstLen).
REQ-006 SHALL have parameter DmaId, default 0, meaning constant ar_id value.
REQ-007 SHALL have one clock and an asynchronous, active-high reset, with ports clk_i and rst_i listed first.
REQ-008 SHALL have these ports, given as name, direction, width, meaning:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- cmd_addr_i  in  AxiAddrWidth  start byte address
- cmd_beats_i  in  16  beat count
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted
- ar_id_o  out  AxiIdWidth  read ID
- ar_addr_o  out  AxiAddrWidth  burst address
- ar_len_o  out  8  beats-1
- ar_size_o  out  3  log2 of bytes per beat
- ar_burst_o  out  2  burst type
- ar_valid_o  out  1  address valid
- ar_ready_i  in  1  address ready
- r_data_i  in  AxiDataWidth  read data
- r_resp_i  in  2  read response
- r_last_i  in  1  last beat
- r_valid_i  in  1  data valid
- r_ready_o  out  1  data ready
- out_data_o  out  AxiDataWidth  stream data
- out_last_o  out  1  final beat of command
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag

Function
REQ-009 SHALL use a state machine with states IDLE, ADDR, DATA and DRAIN; cmd_ready_o SHALL be 1 only in IDLE.
REQ-010 SHALL latch the command on cmd_valid_i && cmd_ready_o and force address bits [log2(AxiDataWidth/8)-1:0] to zero.
REQ-011 SHALL transition from IDLE to DRAIN when it accepts a command with beats=0, issue no AXI traffic, and assert done_o the following cycle.
REQ-012 SHALL set the burst length to the minimum of: remaining beats, MaxBurstLen, and beats left before the next 4 KiB boundary.
REQ-013 SHALL enter ADDR only when free FIFO entries are at least the burst length; otherwise it SHALL wait with ar_valid_o=0.
REQ-014 SHALL hold ar_addr_o and ar_len_o stable while ar_valid_o=1 and ar_ready_i=0.
REQ-015 SHALL drive ar_size_o=log2(AxiDataWidth/8), ar_burst_o=2'b01 (INCR) and ar_id_o=DmaId.
REQ-016 SHALL move from ADDR to DATA on the ar handshake and advance the address by len×bytes and decrement remaining by len.
REQ-017 SHALL keep only one burst outstanding.
REQ-018 SHALL hold r_ready_o=1 in DATA; space is guaranteed by REQ-013.
REQ-019 SHALL push every accepted beat into the FIFO.
REQ-020 SHALL, on r_last_i, go to ADDR if beats remain, else to DRAIN.
REQ-021 SHALL set err_o to 1 on any beat with r_resp_i≠00, still forward that beat's data, and clear err_o only when a new command is accepted.
REQ-022 SHALL mark the FIFO entry of the command's final beat so that out_last_o=1 with it.
REQ-023 SHALL, in DRAIN, go to IDLE once the FIFO is empty and out_last_o has handshaken (or immediately for beats=0), pulsing done_o for 1 cycle in that same cycle.
REQ-024 SHALL hold busy_o=1 in every state other than IDLE.
REQ-025 SHALL, for the FIFO, handle push and pop in the same cycle when full with pop first, give 1-cycle latency from push to out_valid_o, and wrap its pointers modulo FifoDepth.

Reset
REQ-026 SHALL, while rst_i=1, immediately enter IDLE with the FIFO empty and all of these at 0: ar_valid_o, r_ready_o, out_valid_o, out_last_o, busy_o, done_o and err_o; ar_addr_o, ar_len_o and all counters SHALL also be 0.
REQ-027 SHALL, on reset during a burst, abandon the transfer; discarding the remaining R beats after reset is the downstream slave's concern.

Structure
REQ-028 SHALL place the state enum type, the AXI burst/resp encodings (INCR, OKAY, SLVERR) and the 4 KiB boundary constant in package garuda_dma_pkg.
REQ-029 SHALL implement the data buffer as sub-module dma_sync_fifo, parameterised by width (AxiDataWidth+1) and depth, with its own count output.

Verification
REQ-030 SHALL cover: cmd addr 0x8000_0000, beats 40, MaxBurstLen 16 -> ar_len 15, 15, 7 at 0x8000_0000, 0x8000_0080 and 0x8000_0100, 40 stream beats, out_last_o on beat 40, and 1 done_o pulse.
REQ-031 SHALL cover: cmd addr 0x8000_0FF0, beats 4 -> ar bursts len 1 at 0x8000_0FF0 and len 1 at 0x8000_1000.
REQ-032 SHALL cover: cmd beats 0 -> no ar_valid_o, done_o 1 cycle later, and out_valid_o never asserted.
REQ-033 SHALL cover: out_ready_i=0 for 200 cycles during beats 64 -> at most FifoDepth beats buffered, no ar issued without space, and no data loss or reordering.
REQ-034 SHALL cover: r_resp_i=10 on beat 3 of 8 -> err_o=1 from that cycle, all 8 beats delivered, err_o cleared on the next cmd accept.
REQ-035 SHALL cover: rst_i asserted mid-DATA -> all outputs 0 in the same cycle, then a new command completes correctly after release.

Source files
------------

// File: rtl/garuda_dma_pkg.sv
// garuda_dma_pkg: shared state type, AXI encodings and page constant
// for the AXI read DMA.
package garuda_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN
   } dma_state_e;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam int unsigned PAGE_BYTES = 4096;

endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: single-clock FIFO with occupancy count; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module dma_sync_fifo #(
   parameter int Width = 65,
   parameter int Depth = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [Width-1:0]           i_data,
   input  logic                       i_pop,
   output logic [Width-1:0]           o_data,
   output logic                       o_valid,
   output logic [$clog2(Depth+1)-1:0] o_count
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);

   logic [Width-1:0] r_mem [Depth];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != CW'(Depth)) || w_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= nxt(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= nxt(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

endmodule

// File: rtl/axi_read_dma.sv
// axi_read_dma: splits a beat-count read command into AXI INCR bursts
// and streams the returned data out through a buffer FIFO.
module axi_read_dma
   import garuda_dma_pkg::*;
#(
   parameter int AxiIdWidth   = 4,
   parameter int AxiAddrWidth = 64,
   parameter int AxiDataWidth = 64,
   parameter int MaxBurstLen  = 16,
   parameter int FifoDepth    = 32,
   parameter int DmaId        = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [AxiAddrWidth-1:0] cmd_addr_i,
   input  logic [15:0]             cmd_beats_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   output logic [AxiIdWidth-1:0]   ar_id_o,
   output logic [AxiAddrWidth-1:0] ar_addr_o,
   output logic [7:0]              ar_len_o,
   output logic [2:0]              ar_size_o,
   output logic [1:0]              ar_burst_o,
   output logic                    ar_valid_o,
   input  logic                    ar_ready_i,
   input  logic [AxiDataWidth-1:0] r_data_i,
   input  logic [1:0]              r_resp_i,
   input  logic                    r_last_i,
   input  logic                    r_valid_i,
   output logic                    r_ready_o,
   output logic [AxiDataWidth-1:0] out_data_o,
   output logic                    out_last_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   localparam int Bytes = AxiDataWidth / 8;
   localparam int Size  = $clog2(Bytes);
   localparam int CW    = $clog2(FifoDepth + 1);
   localparam int PW    = $clog2(PAGE_BYTES);

   dma_state_e              r_state;
   dma_state_e              w_next;
   logic [AxiAddrWidth-1:0] r_addr;
   logic [15:0]             r_rem;
   logic                    r_err;
   logic                    r_last_done;
   logic [PW:0]             w_page_left;
   logic [PW:0]             w_page_beats;
   logic [16:0]             w_burst;
   logic [CW-1:0]           w_count;
   logic [AxiDataWidth:0]   w_head;
   logic                    w_out_valid;
   logic                    w_space;
   logic                    w_accept;
   logic                    w_ar_fire;
   logic                    w_beat;
   logic                    w_beat_err;
   logic                    w_final;
   logic                    w_pop;

   assign w_page_left  = (PW+1)'(PAGE_BYTES) - {1'b0, r_addr[PW-1:0]};
   assign w_page_beats = w_page_left >> Size;

   always_comb begin
      w_burst = {1'b0, r_rem};
      if (w_burst > 17'(MaxBurstLen))  w_burst = 17'(MaxBurstLen);
      if (w_burst > 17'(w_page_beats)) w_burst = 17'(w_page_beats);
   end

   // A burst is only requested when the whole of it fits in the buffer.
   assign w_space    = (32'(w_count) + 32'(w_burst)) <= 32'(FifoDepth);
   assign w_accept   = cmd_valid_i && cmd_ready_o;
   assign w_ar_fire  = ar_valid_o && ar_ready_i;
   assign w_beat     = r_valid_i && r_ready_o;
   assign w_beat_err = w_beat && (r_resp_i != AXI_RESP_OKAY);
   assign w_final    = r_last_i && (r_rem == '0);
   assign w_pop      = w_out_valid && out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      cmd_ready_o = 1'b0;
      ar_valid_o  = 1'b0;
      ar_len_o    = '0;
      r_ready_o   = 1'b0;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            busy_o      = 1'b0;
            cmd_ready_o = 1'b1;
            if (cmd_valid_i)
               w_next = (cmd_beats_i == '0) ? ST_DRAIN : ST_ADDR;
         end
         ST_ADDR: begin
            ar_len_o = 8'(w_burst - 17'd1);
            if (w_space) begin
               ar_valid_o = 1'b1;
               if (ar_ready_i) w_next = ST_DATA;
            end
         end
         ST_DATA: begin
            r_ready_o = 1'b1;
            if (r_valid_i && r_last_i)
               w_next = (r_rem != '0) ? ST_ADDR : ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((w_count == '0) && r_last_done) begin
               done_o = 1'b1;
               w_next = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr      <= '0;
         r_rem       <= '0;
         r_err       <= 1'b0;
         r_last_done <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr      <= cmd_addr_i & ~AxiAddrWidth'(Bytes - 1);
            r_rem       <= cmd_beats_i;
            r_err       <= 1'b0;
            r_last_done <= (cmd_beats_i == '0);
         end
         if (w_ar_fire) begin
            r_addr <= r_addr + (AxiAddrWidth'(w_burst) << Size);
            r_rem  <= r_rem - w_burst[15:0];
         end
         if (w_beat_err) r_err <= 1'b1;
         if (w_pop && w_head[AxiDataWidth]) r_last_done <= 1'b1;
      end
   end

   dma_sync_fifo #(
      .Width (AxiDataWidth + 1),
      .Depth (FifoDepth)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_beat),
      .i_data  ({w_final, r_data_i}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_valid (w_out_valid),
      .o_count (w_count)
   );

   assign ar_id_o     = AxiIdWidth'(DmaId);
   assign ar_addr_o   = r_addr;
   assign ar_size_o   = 3'(Size);
   assign ar_burst_o  = AXI_BURST_INCR;
   assign out_data_o  = w_head[AxiDataWidth-1:0];
   assign out_last_o  = w_out_valid && w_head[AxiDataWidth];
   assign out_valid_o = w_out_valid;
   assign err_o       = r_err || w_beat_err;

endmodule

// File: tb/tb_axi_read_dma.sv
// tb_axi_read_dma: random AXI slave plus scoreboard for axi_read_dma.
module tb_axi_read_dma;

   localparam int IW  = 4;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int MBL = 16;
   localparam int FD  = 32;
   localparam int ID  = 5;

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
   } ar_t;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] cmd_addr = '0;
   logic [15:0]   cmd_beats = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [IW-1:0] ar_id;
   logic [AW-1:0] ar_addr;
   logic [7:0]    ar_len;
   logic [2:0]    ar_size;
   logic [1:0]    ar_burst;
   logic          ar_valid;
   logic          ar_ready;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic          r_last;
   logic          r_valid;
   logic          r_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic          err;

   axi_read_dma #(
      .AxiIdWidth   (IW),
      .AxiAddrWidth (AW),
      .AxiDataWidth (DW),
      .MaxBurstLen  (MBL),
      .FifoDepth    (FD),
      .DmaId        (ID)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_addr_i  (cmd_addr),
      .cmd_beats_i (cmd_beats),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .ar_id_o     (ar_id),
      .ar_addr_o   (ar_addr),
      .ar_len_o    (ar_len),
      .ar_size_o   (ar_size),
      .ar_burst_o  (ar_burst),
      .ar_valid_o  (ar_valid),
      .ar_ready_i  (ar_ready),
      .r_data_i    (r_data),
      .r_resp_i    (r_resp),
      .r_last_i    (r_last),
      .r_valid_i   (r_valid),
      .r_ready_o   (r_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   ar_t   ar_exp[$];
   beat_t out_exp[$];
   ar_t   sl_q[$];
   int    sl_beat = 0;
   int    occ = 0;
   int    done_cnt = 0;
   logic  err_model = 1'b0;
   logic  stall = 1'b0;
   logic  err_en = 1'b0;
   logic [63:0] err_addr = '0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      return {a[31:0] ^ 32'hDEADBEEF ^ a[63:32], a[31:0]};
   endfunction

   // Reference: split into bursts bounded by MBL and the 4 KiB page.
   task automatic model_cmd(input logic [63:0] addr, input int beats);
      logic [63:0] a;
      int rem, bnd, n;
      a   = addr & ~64'd7;
      rem = beats;
      while (rem > 0) begin
         bnd = (4096 - int'(a[11:0])) / 8;
         n = rem;
         if (n > MBL) n = MBL;
         if (n > bnd) n = bnd;
         ar_exp.push_back('{a, 8'(n - 1)});
         for (int k = 0; k < n; k++)
            out_exp.push_back('{mem_word(a + 64'(8 * k)),
                                (rem == n) && (k == n - 1)});
         a   = a + 64'(8 * n);
         rem = rem - n;
      end
   endtask

   // AXI slave
   logic        sl_arf, sl_rf;
   logic [63:0] sl_cap_addr, sl_beat_addr;
   logic [7:0]  sl_cap_len;
   initial begin
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      r_data   = '0;
      r_resp   = 2'b00;
      r_last   = 1'b0;
      forever begin
         @(negedge clk);
         sl_arf      = ar_valid && ar_ready && !rst;
         sl_rf       = r_valid && r_ready && !rst;
         sl_cap_addr = ar_addr;
         sl_cap_len  = ar_len;
         @(posedge clk);
         #1;
         if (rst) begin
            sl_q.delete();
            sl_beat  = 0;
            ar_ready = 1'b0;
            r_valid  = 1'b0;
         end else begin
            if (sl_arf) sl_q.push_back('{sl_cap_addr, sl_cap_len});
            if (sl_rf && sl_q.size() > 0) begin
               if (sl_beat == int'(sl_q[0].len)) begin
                  void'(sl_q.pop_front());
                  sl_beat = 0;
               end else begin
                  sl_beat++;
               end
            end
            ar_ready = ($urandom_range(0, 3) != 0);
            if (r_valid && !sl_rf) begin
               r_valid = 1'b1;
            end else if (sl_q.size() > 0 && $urandom_range(0, 3) != 0) begin
               sl_beat_addr = sl_q[0].addr + 64'(8 * sl_beat);
               r_valid = 1'b1;
               r_data  = mem_word(sl_beat_addr);
               r_last  = (sl_beat == int'(sl_q[0].len));
               r_resp  = (err_en && sl_beat_addr == err_addr) ? 2'b10 : 2'b00;
            end else begin
               r_valid = 1'b0;
            end
         end
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor and scoreboard
   logic        ar_pend = 1'b0;
   logic [63:0] pend_addr;
   logic [7:0]  pend_len;
   ar_t         m_ar;
   beat_t       m_beat;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            ar_pend   = 1'b0;
            occ       = 0;
            err_model = 1'b0;
         end else begin
            if (ar_pend) begin
               check("ar_hold_valid", ar_valid, 1);
               check("ar_hold_addr", ar_addr, pend_addr);
               check("ar_hold_len", ar_len, pend_len);
            end
            ar_pend   = ar_valid && !ar_ready;
            pend_addr = ar_addr;
            pend_len  = ar_len;
            if (ar_valid && ar_ready) begin
               check("ar_expected", ar_exp.size() != 0, 1);
               if (ar_exp.size() != 0) begin
                  m_ar = ar_exp.pop_front();
                  check("ar_addr", ar_addr, m_ar.addr);
                  check("ar_len", ar_len, m_ar.len);
                  check("ar_size", ar_size, 3);
                  check("ar_burst", ar_burst, 1);
                  check("ar_id", ar_id, ID);
                  check("ar_space", occ + int'(ar_len) + 1 <= FD, 1);
               end
            end
            if (out_valid && out_ready) begin
               check("out_expected", out_exp.size() != 0, 1);
               if (out_exp.size() != 0) begin
                  m_beat = out_exp.pop_front();
                  check("out_data", out_data, m_beat.data);
                  check("out_last", out_last, m_beat.last);
               end
            end
            if (r_valid && r_ready) begin
               check("err_on_beat", err, err_model | (r_resp != 2'b00));
               if (r_resp != 2'b00) err_model = 1'b1;
            end
            if (cmd_valid && cmd_ready) err_model = 1'b0;
            occ = occ + int'(r_valid && r_ready) - int'(out_valid && out_ready);
            if (done) done_cnt++;
         end
      end
   end

   task automatic start_cmd(input logic [63:0] addr, input int beats);
      model_cmd(addr, beats);
      @(posedge clk);
      #1;
      cmd_addr  = addr;
      cmd_beats = 16'(beats);
      cmd_valid = 1'b1;
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready, 1);
      check("done_before_accept", done, 0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("err_clear_on_accept", err, 0);
   endtask

   task automatic wait_done(input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("done_seen", done_cnt >= target, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("done_pulse_count", done_cnt, target);
      check("busy_idle", busy, 0);
      check("ar_queue_empty", ar_exp.size(), 0);
      check("out_queue_empty", out_exp.size(), 0);
   endtask

   task automatic run_cmd(input logic [63:0] addr, input int beats);
      int tgt;
      tgt = done_cnt + 1;
      start_cmd(addr, beats);
      wait_done(tgt, 3000);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {ar_valid, r_ready, out_valid, out_last, busy, done, err}, 0);
      check({name, "_addr"}, ar_addr, 0);
      check({name, "_len"}, ar_len, 0);
   endtask

   initial begin
      int n, tgt;
      logic [63:0] a;
      #3;
      check_reset_outputs("reset_init");
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;

      run_cmd(64'h8000_0000, 40);
      run_cmd(64'h8000_0FF0, 4);

      tgt = done_cnt + 1;
      start_cmd(64'h8000_2000, 0);
      @(negedge clk);
      check("zero_done_next", done, 1);
      @(negedge clk);
      check("zero_done_once", done, 0);
      wait_done(tgt, 20);

      stall = 1'b1;
      tgt = done_cnt + 1;
      start_cmd(64'h4000_0000, 64);
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("stall_fifo_full", occ, FD);
      check("stall_ar_pending", ar_exp.size(), 2);
      stall = 1'b0;
      wait_done(tgt, 3000);

      err_en   = 1'b1;
      err_addr = 64'h2000_0010;
      run_cmd(64'h2000_0000, 8);
      check("err_sticky", err, 1);
      err_en = 1'b0;
      run_cmd(64'h2000_0100, 5);

      start_cmd(64'h3000_0000, 64);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(r_ready && occ >= 3) && n < 500);
      check("reach_data", r_ready, 1);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("reset_mid");
      ar_exp.delete();
      out_exp.delete();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      run_cmd(64'h3000_0108, 20);

      for (int i = 0; i < 6; i++) begin
         a = 64'(32'h5000_0000 + 32'($urandom_range(1, 8)) * 32'd4096
                 - 32'($urandom_range(0, 400)));
         run_cmd(a, $urandom_range(1, 60));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
